// File: rtl/program_loader.sv
// program_loader: host-side writer for the 9-bit core's instruction memory.
// Receives a framed byte stream (HEADER, LEN, LEN x {LO, HI}, CSUM), packs each
// byte pair into one instruction and writes them from address 0 upward. If the
// checksum matches, it pulses start to the core and waits for core_done.
//
// Ports:
//   clk, reset       clock (rising edge), asynchronous active-low reset
//   in_valid/in_data host byte stream; in_ready is the registered accept flag
//   imem_wen/addr/wdata  instruction memory write port (one-cycle write strobe)
//   start            one-cycle start pulse to the core
//   core_done        core completion level
//   busy             high whenever the loader is not idle
//   load_ok          sticky checksum-match flag
//   err              sticky error code: 01 checksum, 10 bad pad bits, 11 zero length
module program_loader #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned INSTR_W = 9,
  parameter logic [7:0]  HEADER  = 8'hA5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  input  logic [7:0]         in_data,
  output logic               in_ready,
  output logic               imem_wen,
  output logic [ADDR_W-1:0]  imem_addr,
  output logic [INSTR_W-1:0] imem_wdata,
  output logic               start,
  input  logic               core_done,
  output logic               busy,
  output logic               load_ok,
  output logic [1:0]         err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_LO,
    S_HI,
    S_CSUM,
    S_START,
    S_RUN
  } state_t;

  state_t     state;
  state_t     state_d;
  logic [7:0] len_q;
  logic [7:0] idx_q;
  logic [7:0] lo_q;
  logic [7:0] csum_q;
  logic       run_armed_q;

  logic       acc;
  logic       pad_ok;
  logic       last_pair;

  assign acc       = in_valid && in_ready;
  assign pad_ok    = (in_data[7:1] == 7'd0);
  assign last_pair = ((idx_q + 8'd1) == len_q);

  // Next-state decode; only accepted bytes advance the byte-consuming states.
  always_comb begin
    state_d = state;
    case (state)
      S_IDLE:  if (acc && (in_data == HEADER)) state_d = S_LEN;
      S_LEN:   if (acc) state_d = (in_data == 8'd0) ? S_IDLE : S_LO;
      S_LO:    if (acc) state_d = S_HI;
      S_HI:    if (acc) state_d = !pad_ok ? S_IDLE : (last_pair ? S_CSUM : S_LO);
      S_CSUM:  if (acc) state_d = (in_data == csum_q) ? S_START : S_IDLE;
      S_START: state_d = S_RUN;
      // run_armed_q masks a done level left over from a previous run.
      S_RUN:   if (run_armed_q && core_done) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State, datapath and all registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      in_ready    <= 1'b0;
      imem_wen    <= 1'b0;
      imem_addr   <= '0;
      imem_wdata  <= '0;
      start       <= 1'b0;
      busy        <= 1'b0;
      load_ok     <= 1'b0;
      err         <= 2'b00;
      len_q       <= 8'd0;
      idx_q       <= 8'd0;
      lo_q        <= 8'd0;
      csum_q      <= 8'd0;
      run_armed_q <= 1'b0;
    end else begin
      state       <= state_d;
      // Outputs follow the state being entered so they line up with it.
      in_ready    <= (state_d != S_START) && (state_d != S_RUN);
      busy        <= (state_d != S_IDLE);
      start       <= (state_d == S_START);
      imem_wen    <= 1'b0;
      run_armed_q <= (state == S_RUN);
      if (acc) begin
        case (state)
          S_IDLE: begin
            if (in_data == HEADER) begin
              err     <= 2'b00;
              load_ok <= 1'b0;
            end
          end
          S_LEN: begin
            if (in_data == 8'd0) begin
              err <= 2'b11;
            end else begin
              len_q  <= in_data;
              csum_q <= in_data;
              idx_q  <= 8'd0;
            end
          end
          S_LO: begin
            lo_q   <= in_data;
            csum_q <= csum_q ^ in_data;
          end
          S_HI: begin
            if (!pad_ok) begin
              err <= 2'b10;
            end else begin
              imem_wen   <= 1'b1;
              imem_addr  <= ADDR_W'(idx_q);
              imem_wdata <= INSTR_W'({in_data[0], lo_q});
              csum_q     <= csum_q ^ in_data;
              idx_q      <= idx_q + 8'd1;
            end
          end
          S_CSUM: begin
            if (in_data == csum_q) load_ok <= 1'b1;
            else                   err     <= 2'b01;
          end
          default: ;
        endcase
      end
    end
  end

endmodule
